// File: rtl/riscv_multicycle_ctrl.sv
// Multicycle RISC-V control FSM: fetch, execute, memory/FPU wait, write-back sequencing.
// Optional memory-wait timeout to a sticky FAULT state is enabled by defining RISCV_MC_TIMEOUT_EN.
module riscv_multicycle_ctrl #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int unsigned     MAX_WAIT = 15
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_ack,
  input  logic [XLEN-1:0] dmem_rdata,
  input  logic            dec_is_load,
  input  logic            dec_is_store,
  input  logic            dec_uses_fpu,
  input  logic            dec_writes_reg,
  input  logic [XLEN-1:0] exec_addr,
  input  logic [XLEN-1:0] exec_wdata,
  input  logic [XLEN-1:0] next_pc,
  input  logic            fpu_busy,
  output logic [31:0]     instr,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] mem_rdata,
  output logic            reg_we,
  output logic [2:0]      state,
  output logic            fault,
  output logic [63:0]     instret
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FETCH    = 3'd1,
    EXEC     = 3'd2,
    MEM      = 3'd3,
    FPU_WAIT = 3'd4,
    WB       = 3'd5,
    FAULT    = 3'd6
  } state_t;

  state_t cur_state, nxt_state;

  logic            is_load_lat;
  logic            is_store_lat;
  logic            writes_reg_lat;
  logic [XLEN-1:0] addr_lat;
  logic [XLEN-1:0] wdata_lat;
  logic [XLEN-1:0] next_pc_lat;
  logic            wait_hit;

  if (MAX_WAIT < 1 || MAX_WAIT > 255) begin : g_bad_max_wait
    $error("riscv_multicycle_ctrl: MAX_WAIT must be in 1..255");
  end

`ifdef RISCV_MC_TIMEOUT_EN
  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  logic [7:0] wait_cnt;
  logic       waiting;

  assign waiting  = (cur_state == FETCH && !imem_ack) || (cur_state == MEM && !dmem_ack);
  // Trip on the cycle that would bring the count to MAX_WAIT without an ack.
  assign wait_hit = waiting && (wait_cnt == WAIT_LAST);
  assign fault    = (cur_state == FAULT);

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if ((nxt_state == FETCH && cur_state != FETCH) ||
                 (nxt_state == MEM && cur_state != MEM)) begin
      wait_cnt <= '0;
    end else if (waiting) begin
      wait_cnt <= wait_cnt + 8'd1;
    end
  end
`else
  assign wait_hit = 1'b0;
  assign fault    = 1'b0;
`endif

  always_comb begin
    nxt_state = cur_state;
    case (cur_state)
      IDLE:     nxt_state = FETCH;
      FETCH: begin
        if (imem_ack)      nxt_state = EXEC;
        else if (wait_hit) nxt_state = FAULT;
      end
      EXEC: begin
        if (dec_is_load || dec_is_store) nxt_state = MEM;
        else if (dec_uses_fpu)           nxt_state = FPU_WAIT;
        else                             nxt_state = WB;
      end
      MEM: begin
        if (dmem_ack)      nxt_state = WB;
        else if (wait_hit) nxt_state = FAULT;
      end
      FPU_WAIT: begin
        if (!fpu_busy) nxt_state = WB;
      end
      WB:       nxt_state = FETCH;
      FAULT:    nxt_state = FAULT;
      default:  nxt_state = IDLE;
    endcase
  end

  // Moore handshake outputs: requests fall the cycle after the acking edge.
  assign imem_req   = (cur_state == FETCH);
  assign imem_addr  = pc;
  assign dmem_req   = (cur_state == MEM);
  assign dmem_we    = (cur_state == MEM) && is_store_lat;
  assign dmem_addr  = addr_lat;
  assign dmem_wdata = wdata_lat;
  assign reg_we     = (cur_state == WB) && writes_reg_lat && !is_store_lat;
  assign state      = cur_state;

  always_ff @(posedge clk) begin
    if (reset) begin
      cur_state <= IDLE;
      pc        <= RESET_PC;
      instr     <= '0;
      mem_rdata <= '0;
      instret   <= '0;
    end else begin
      cur_state <= nxt_state;
      if (cur_state == FETCH && imem_ack) begin
        instr <= imem_rdata;
      end
      if (cur_state == MEM && dmem_ack && is_load_lat) begin
        mem_rdata <= dmem_rdata;
      end
      if (cur_state == WB) begin
        pc      <= next_pc_lat;
        instret <= instret + 64'd1;
      end
    end
  end

  // Decode/execute snapshot; a load+store combination is resolved as a store.
  always_ff @(posedge clk) begin
    if (cur_state == EXEC) begin
      is_load_lat    <= dec_is_load && !dec_is_store;
      is_store_lat   <= dec_is_store;
      writes_reg_lat <= dec_writes_reg;
      addr_lat       <= exec_addr;
      wdata_lat      <= exec_wdata;
      next_pc_lat    <= next_pc;
    end
  end

endmodule

// File: tb/tb_riscv_multicycle_ctrl.sv
// Scoreboard bench for riscv_multicycle_ctrl: write-back expectations are queued when an
// instruction is driven and compared when the FSM reaches WB.
module tb_riscv_multicycle_ctrl;

  localparam int XLEN     = 32;
  localparam int MAX_WAIT = 15;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_EXEC  = 3'd2;
  localparam logic [2:0] S_MEM   = 3'd3;
  localparam logic [2:0] S_FPU   = 3'd4;
  localparam logic [2:0] S_WB    = 3'd5;
  localparam logic [2:0] S_FAULT = 3'd6;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            imem_req, imem_ack = 1'b0;
  logic [XLEN-1:0] imem_addr;
  logic [31:0]     imem_rdata = '0;
  logic            dmem_req, dmem_we, dmem_ack = 1'b0;
  logic [XLEN-1:0] dmem_addr, dmem_wdata, dmem_rdata = '0;
  logic            dec_is_load = 1'b0, dec_is_store = 1'b0, dec_uses_fpu = 1'b0, dec_writes_reg = 1'b0;
  logic [XLEN-1:0] exec_addr = '0, exec_wdata = '0, next_pc = '0;
  logic            fpu_busy = 1'b0;
  logic [31:0]     instr;
  logic [XLEN-1:0] pc, mem_rdata;
  logic            reg_we, fault;
  logic [2:0]      state;
  logic [63:0]     instret;

  riscv_multicycle_ctrl #(.XLEN(XLEN), .RESET_PC(32'h0), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .dec_is_load(dec_is_load), .dec_is_store(dec_is_store), .dec_uses_fpu(dec_uses_fpu),
    .dec_writes_reg(dec_writes_reg), .exec_addr(exec_addr), .exec_wdata(exec_wdata),
    .next_pc(next_pc), .fpu_busy(fpu_busy), .instr(instr), .pc(pc), .mem_rdata(mem_rdata),
    .reg_we(reg_we), .state(state), .fault(fault), .instret(instret)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        reg_we;
    logic [31:0] instr;
    logic [31:0] mem_rdata;
  } wb_exp_t;

  wb_exp_t         sb[$];
  wb_exp_t         mon_e;
  int              total = 0;
  int              bad = 0;
  logic [XLEN-1:0] pc_model = '0;
  logic [63:0]     instret_model = '0;
  logic [XLEN-1:0] mem_model = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_state(input logic [2:0] s, input int lim);
    int n = 0;
    while (state !== s && n < lim) begin
      tick();
      n++;
    end
    check("wait_state", state, s);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    imem_ack = 1'b0; dmem_ack = 1'b0; fpu_busy = 1'b0;
    tick(); tick();
    check("rst_state", state, S_IDLE);
    check("rst_pc", pc, 32'h0);
    check("rst_instret", instret, 64'd0);
    check("rst_fault", fault, 1'b0);
    check("rst_ireq", imem_req, 1'b0);
    check("rst_dreq", dmem_req, 1'b0);
    check("rst_dwe", dmem_we, 1'b0);
    check("rst_rwe", reg_we, 1'b0);
    check("rst_instr", instr, 32'h0);
    check("rst_mrd", mem_rdata, 32'h0);
    pc_model = '0; instret_model = '0; mem_model = '0;
    reset = 1'b0;
    check("idle_hold", state, S_IDLE);
    tick();
    check("idle_to_fetch", state, S_FETCH);
  endtask

  // Drive one instruction from FETCH through WB, checking each state on the way.
  task automatic do_instr(input logic [31:0] iw, input int fdly, input logic ld, input logic st,
                          input logic fpu, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] npc,
                          input logic [31:0] rdata, input int mdly, input int fbusy);
    wb_exp_t e;
    int nf;
    wait_state(S_FETCH, 50);
    if (ld && !st) mem_model = rdata;
    e.reg_we = wr & ~st;
    e.instr = iw;
    e.mem_rdata = mem_model;
    sb.push_back(e);
    for (int i = 0; i < fdly; i++) begin
      imem_ack = 1'b0;
      check("f_req", imem_req, 1'b1);
      check("f_addr", imem_addr, pc_model);
      tick();
    end
    check("f_state", state, S_FETCH);
    check("f_addr", imem_addr, pc_model);
    imem_ack = 1'b1; imem_rdata = iw;
    dec_is_load = ld; dec_is_store = st; dec_uses_fpu = fpu; dec_writes_reg = wr;
    exec_addr = addr; exec_wdata = wdata; next_pc = npc;
    tick();
    check("exec_state", state, S_EXEC);
    check("exec_ireq", imem_req, 1'b0);
    check("exec_instr", instr, iw);
    check("exec_rwe", reg_we, 1'b0);
    // Stray acks while no request is pending must be ignored.
    imem_ack = 1'b1; imem_rdata = ~iw; dmem_ack = 1'b1; dmem_rdata = 32'hBAD0BAD0;
    fpu_busy = (fbusy > 0);
    tick();
    imem_ack = 1'b0; dmem_ack = 1'b0;
    dec_is_load = ~ld; dec_is_store = ~st; dec_uses_fpu = ~fpu; dec_writes_reg = ~wr;
    exec_addr = ~addr; exec_wdata = ~wdata; next_pc = ~npc;
    if (ld || st) begin
      for (int i = 0; i <= mdly; i++) begin
        check("mem_state", state, S_MEM);
        check("mem_req", dmem_req, 1'b1);
        check("mem_we", dmem_we, st);
        check("mem_addr", dmem_addr, addr);
        check("mem_wdata", dmem_wdata, wdata);
        dmem_ack = (i == mdly);
        dmem_rdata = (i == mdly) ? rdata : 32'hBAD0BAD0;
        tick();
      end
      dmem_ack = 1'b0;
    end else if (fpu) begin
      nf = 0;
      while (state == S_FPU && nf < 100) begin
        nf++;
        fpu_busy = (nf < fbusy);
        tick();
      end
      check("fpu_cycles", nf, (fbusy > 1) ? fbusy : 1);
      fpu_busy = 1'b0;
    end
    check("wb_state", state, S_WB);
    check("wb_dreq", dmem_req, 1'b0);
    imem_ack = 1'b1; dmem_ack = 1'b1;
    tick();
    imem_ack = 1'b0; dmem_ack = 1'b0;
    pc_model = npc;
    instret_model = instret_model + 64'd1;
    check("next_state", state, S_FETCH);
    check("next_pc", pc, pc_model);
    check("instret", instret, instret_model);
  endtask

  always @(negedge clk) begin
    if (!reset && state == S_WB) begin
      check("sb_nonempty", sb.size() != 0, 1'b1);
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        check("wb_rwe", reg_we, mon_e.reg_we);
        check("wb_instr", instr, mon_e.instr);
        check("wb_mrd", mem_rdata, mon_e.mem_rdata);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog state=%0d", state);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int kind, n;
    logic [31:0] a, w, r;
    do_reset();

    do_instr(32'h00500093, 0, 0, 0, 0, 1, 32'h0,   32'h0,  32'h4,  32'h0,        0, 0);
    do_instr(32'h10002083, 0, 1, 0, 0, 1, 32'h100, 32'h0,  32'h8,  32'hDEADBEEF, 3, 0);
    do_instr(32'h20502023, 1, 0, 1, 0, 1, 32'h200, 32'h55, 32'hC,  32'h0,        0, 0);
    do_instr(32'h00208053, 0, 0, 0, 1, 1, 32'h0,   32'h0,  32'h10, 32'h0,        0, 5);
    do_instr(32'h30302023, 0, 1, 1, 0, 1, 32'h300, 32'h77, 32'h14, 32'h11111111, 1, 0);
    do_instr(32'h00000013, 2, 0, 0, 0, 0, 32'h0,   32'h0,  32'h18, 32'h0,        0, 0);

    for (int i = 0; i < 10; i++) begin
      kind = $urandom_range(0, 3);
      a = $urandom; w = $urandom; r = $urandom;
      do_instr($urandom, $urandom_range(0, 3), kind == 1, kind == 2, kind == 3,
               1'($urandom_range(0, 1)), a, w, pc_model + 32'h4, r,
               $urandom_range(0, 3), (kind == 3) ? $urandom_range(0, 4) : 0);
    end

    wait_state(S_FETCH, 50);
`ifdef RISCV_MC_TIMEOUT_EN
    n = 0;
    imem_ack = 1'b0;
    while (state == S_FETCH && n < 100) begin
      tick();
      n++;
    end
    check("to_cycles", n, MAX_WAIT);
    check("to_state", state, S_FAULT);
    check("to_fault", fault, 1'b1);
    check("to_ireq", imem_req, 1'b0);
    check("to_dreq", dmem_req, 1'b0);
    imem_ack = 1'b1;
    tick();
    imem_ack = 1'b0;
    check("to_sticky", state, S_FAULT);
    check("to_sticky_fault", fault, 1'b1);
`else
    imem_ack = 1'b0;
    for (int i = 0; i < 40; i++) tick();
    check("nto_state", state, S_FETCH);
    check("nto_fault", fault, 1'b0);
    check("nto_addr", imem_addr, pc_model);
    do_instr(32'h00100073, 0, 0, 0, 0, 1, 32'h0, 32'h0, pc_model + 32'h4, 32'h0, 0, 0);
`endif

    // Reset in the middle of a load aborts it; the coincident ack is lost.
    do_reset();
    do_instr(32'h00000013, 0, 0, 0, 0, 1, 32'h0, 32'h0, 32'h40, 32'h0, 0, 0);
    imem_ack = 1'b1; imem_rdata = 32'h40002083;
    dec_is_load = 1'b1; dec_is_store = 1'b0; dec_uses_fpu = 1'b0; dec_writes_reg = 1'b1;
    exec_addr = 32'h300; exec_wdata = 32'h0; next_pc = 32'h44;
    tick();
    imem_ack = 1'b0;
    tick();
    check("ab_mem", state, S_MEM);
    reset = 1'b1; dmem_ack = 1'b1; dmem_rdata = 32'h12345678;
    tick();
    dmem_ack = 1'b0;
    check("ab_state", state, S_IDLE);
    check("ab_instret", instret, 64'd0);
    check("ab_mrd", mem_rdata, 32'h0);
    check("ab_pc", pc, 32'h0);
    check("ab_dreq", dmem_req, 1'b0);
    check("ab_rwe", reg_we, 1'b0);
    sb.delete(sb.size() - 1 >= 0 ? sb.size() : 0);
    do_reset();
    do_instr(32'h00400093, 0, 0, 0, 0, 1, 32'h0, 32'h0, 32'h4, 32'h0, 0, 0);
    check("sb_drain", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
